// File: rtl/pilha_pkg.sv
// Shared constants for the parameterised LIFO stack.
// Default geometry and write-source select encodings.
package pilha_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    localparam logic SRC_UC  = 1'b0;
    localparam logic SRC_ULA = 1'b1;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL,
        OP_PUSH_UDF,
        OP_OVF,
        OP_UDF
    } pilha_op_e;

endpackage

// File: rtl/pilha_mem.sv
// Stack storage: register array with a synchronous write port
// and a combinational read port.
module pilha_mem
    import pilha_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pilha_param.sv
// LIFO stack control: occupancy pointer, sticky error flags
// and the registered pop output.
module pilha_param
    import pilha_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               src_sel,
    input  logic [WIDTH-1:0]   din_uc,
    input  logic [2*WIDTH-1:0] din_ula,
    input  logic               clr_err,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid,
    output logic [IDX_W:0]     tos,
    output logic               full,
    output logic               empty,
    output logic               ovf,
    output logic               udf
);

    localparam logic [IDX_W:0] TOS_MAX = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] TOS_ONE = (IDX_W+1)'(1);

    logic [IDX_W:0]   r_tos;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_ovf;
    logic             r_udf;

    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata;
    logic [IDX_W-1:0] w_top;
    logic [IDX_W-1:0] w_waddr;
    logic             w_we;
    logic             w_take;
    logic             w_ovf_set;
    logic             w_udf_set;
    logic [IDX_W:0]   w_tos_nxt;
    pilha_op_e        w_op;

    assign w_full  = (r_tos == TOS_MAX);
    assign w_empty = (r_tos == '0);

    assign w_wdata = (src_sel == SRC_ULA) ? din_ula[WIDTH-1:0] : din_uc;

    // Low bits wrap to DEPTH-1 when full, which is exactly the top slot.
    assign w_top = r_tos[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        w_op = OP_IDLE;
        unique case (1'b1)
            (push &  pop & ~w_empty): w_op = OP_REPL;
            (push &  pop &  w_empty): w_op = OP_PUSH_UDF;
            (push & ~pop & ~w_full):  w_op = OP_PUSH;
            (push & ~pop &  w_full):  w_op = OP_OVF;
            (~push & pop & ~w_empty): w_op = OP_POP;
            (~push & pop &  w_empty): w_op = OP_UDF;
            default:                  w_op = OP_IDLE;
        endcase
    end

    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_tos[IDX_W-1:0];
        w_take    = 1'b0;
        w_ovf_set = 1'b0;
        w_udf_set = 1'b0;
        w_tos_nxt = r_tos;
        unique case (w_op)
            OP_PUSH: begin
                w_we      = 1'b1;
                w_tos_nxt = r_tos + TOS_ONE;
            end
            OP_PUSH_UDF: begin
                w_we      = 1'b1;
                w_udf_set = 1'b1;
                w_tos_nxt = r_tos + TOS_ONE;
            end
            OP_REPL: begin
                w_we    = 1'b1;
                w_waddr = w_top;
                w_take  = 1'b1;
            end
            OP_POP: begin
                w_take    = 1'b1;
                w_tos_nxt = r_tos - TOS_ONE;
            end
            OP_OVF:  w_ovf_set = 1'b1;
            OP_UDF:  w_udf_set = 1'b1;
            default: ;
        endcase
    end

    pilha_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we & ~rst),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_top),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tos        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
        end else begin
            r_tos        <= w_tos_nxt;
            r_dout_valid <= w_take;
            if (w_take) begin
                r_dout <= w_rdata;
            end
            r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
            r_udf <= w_udf_set | (r_udf & ~clr_err);
        end
    end

    assign tos        = r_tos;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign full       = w_full;
    assign empty      = w_empty;
    assign ovf        = r_ovf;
    assign udf        = r_udf;

endmodule

// File: tb/tb_pilha_param.sv
// Self-checking bench for pilha_param: directed scenarios plus
// random traffic compared against a queue-based stack model.
module tb_pilha_param;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int IDX_W = $clog2(DEPTH);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               push = 1'b0;
    logic               pop = 1'b0;
    logic               src_sel = 1'b0;
    logic [WIDTH-1:0]   din_uc = '0;
    logic [2*WIDTH-1:0] din_ula = '0;
    logic               clr_err = 1'b0;
    logic [WIDTH-1:0]   dout;
    logic               dout_valid;
    logic [IDX_W:0]     tos;
    logic               full;
    logic               empty;
    logic               ovf;
    logic               udf;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_valid = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_udf = 1'b0;

    pilha_param #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .src_sel    (src_sel),
        .din_uc     (din_uc),
        .din_ula    (din_ula),
        .clr_err    (clr_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .tos        (tos),
        .full       (full),
        .empty      (empty),
        .ovf        (ovf),
        .udf        (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one clock edge, stack as a queue.
    task automatic model_edge();
        logic [WIDTH-1:0] w;
        logic             n_ovf;
        logic             n_udf;
        w = src_sel ? din_ula[WIDTH-1:0] : din_uc;
        if (rst) begin
            m_q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            return;
        end
        m_valid = 1'b0;
        n_ovf   = clr_err ? 1'b0 : m_ovf;
        n_udf   = clr_err ? 1'b0 : m_udf;
        if (push && pop) begin
            if (m_q.size() == 0) begin
                m_q.push_back(w);
                n_udf = 1'b1;
            end else begin
                m_dout = m_q[m_q.size()-1];
                m_q[m_q.size()-1] = w;
                m_valid = 1'b1;
            end
        end else if (push) begin
            if (m_q.size() == DEPTH) n_ovf = 1'b1;
            else m_q.push_back(w);
        end else if (pop) begin
            if (m_q.size() == 0) n_udf = 1'b1;
            else begin
                m_dout  = m_q.pop_back();
                m_valid = 1'b1;
            end
        end
        m_ovf = n_ovf;
        m_udf = n_udf;
    endtask

    task automatic check_all();
        check("tos", 32'(tos), 32'(m_q.size()));
        check("full", 32'(full), 32'(m_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("dout", 32'(dout), 32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
    endtask

    task automatic step(input logic pu, input logic po, input logic sel,
                        input logic [WIDTH-1:0] uc,
                        input logic [2*WIDTH-1:0] ula,
                        input logic clr, input logic r);
        push    = pu;
        pop     = po;
        src_sel = sel;
        din_uc  = uc;
        din_ula = ula;
        clr_err = clr;
        rst     = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_push(input logic [WIDTH-1:0] v);
        step(1'b1, 1'b0, 1'b0, v, '0, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_idle(input logic clr);
        step(1'b0, 1'b0, 1'b0, '0, '0, clr, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_tos", 32'(tos), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);

        do_push(16'h1111);
        do_push(16'h2222);
        do_pop();
        check("lifo_first", 32'(dout), 32'h2222);
        check("lifo_first_v", 32'(dout_valid), 32'd1);
        do_pop();
        check("lifo_second", 32'(dout), 32'h1111);
        do_idle(1'b0);
        check("valid_pulse", 32'(dout_valid), 32'd0);
        check("drained", 32'(empty), 32'd1);

        step(1'b1, 1'b0, 1'b1, 16'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_pop();
        check("ula_low", 32'(dout), 32'hBEEF);

        for (int i = 0; i < DEPTH; i++) do_push(WIDTH'(16'h0100 + i));
        do_push(16'hFFFF);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_tos", 32'(tos), 32'd16);
        check("ovf_flag", 32'(ovf), 32'd1);
        do_pop();
        check("ovf_top", 32'(dout), 32'h010F);
        do_idle(1'b1);
        check("ovf_clr", 32'(ovf), 32'd0);
        for (int i = 0; i < DEPTH - 1; i++) do_pop();

        do_pop();
        check("udf_flag", 32'(udf), 32'd1);
        check("udf_tos", 32'(tos), 32'd0);
        check("udf_valid", 32'(dout_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
        check("udf_prio", 32'(udf), 32'd1);
        do_idle(1'b1);
        step(1'b1, 1'b1, 1'b0, 16'h0042, '0, 1'b0, 1'b0);
        check("pp_empty_tos", 32'(tos), 32'd1);
        check("pp_empty_udf", 32'(udf), 32'd1);
        do_reset();

        do_push(16'h000A);
        do_push(16'h000B);
        step(1'b1, 1'b1, 1'b0, 16'h000C, '0, 1'b0, 1'b0);
        check("repl_dout", 32'(dout), 32'h000B);
        check("repl_tos", 32'(tos), 32'd2);
        do_pop();
        check("repl_new", 32'(dout), 32'h000C);

        do_reset();
        for (int i = 0; i < 5; i++) do_push(WIDTH'(16'h5000 + i));
        do_reset();
        check("mid_rst_tos", 32'(tos), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        check("mid_rst_flags", 32'({ovf, udf}), 32'd0);
        do_pop();
        check("mid_rst_udf", 32'(udf), 32'd1);

        for (int i = 0; i < 600; i++) begin
            automatic int r = $urandom_range(0, 99);
            automatic logic pu = (r < 45) || (r >= 80 && r < 90);
            automatic logic po = (r >= 45 && r < 80) || (r >= 80 && r < 90);
            step(pu, po, 1'($urandom), WIDTH'($urandom), $urandom,
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 79) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pilha_param.md
PILHA_PARAM -- requirements
Module: pilha_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, stored word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (>=2).
REQ-003 SHALL have parameter IDX_W, default $clog2(DEPTH), index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port push  input  1  write request.
REQ-007 SHALL have port pop  input  1  read request.
REQ-008 SHALL have port src_sel  input  1  write source select: 0 = control unit, 1 = ALU.
REQ-009 SHALL have port din_uc  input  WIDTH  control-unit write data.
REQ-010 SHALL have port din_ula  input  2*WIDTH  ALU write data; only bits [WIDTH-1:0] are stored.
REQ-011 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-012 SHALL have port dout  output  WIDTH  registered popped word.
REQ-013 SHALL have port dout_valid  output  1  one-cycle pulse, dout updated this cycle.
REQ-014 SHALL have port tos  output  IDX_W+1  current occupancy (0..DEPTH).
REQ-015 SHALL have ports full, empty  output  1 each  tos==DEPTH / tos==0, combinational from tos.
REQ-016 SHALL have ports ovf, udf  output  1 each  sticky overflow / underflow flags.

Function
REQ-017 Write data SHALL be din_uc when src_sel=0, din_ula[WIDTH-1:0] when src_sel=1.
REQ-018 push=1, pop=0, not full: mem[tos] <= write data; tos <= tos+1; dout unchanged.
REQ-019 pop=1, push=0, not empty: dout <= mem[tos-1]; dout_valid <= 1; tos <= tos-1; latency one cycle.
REQ-020 push=1, pop=1, not empty (including full): replace top: dout <= old mem[tos-1], mem[tos-1] <= write data, tos unchanged, dout_valid <= 1.
REQ-021 push=1, pop=1, empty: ordinary push (REQ-018); udf <= 1; dout_valid stays 0.
REQ-022 push=1, pop=0, full: write ignored, tos unchanged, ovf <= 1.
REQ-023 pop=1, push=0, empty: tos unchanged, dout unchanged, dout_valid 0, udf <= 1.
REQ-024 push=0, pop=0: tos, dout, memory unchanged; dout_valid 0.
REQ-025 dout_valid SHALL be high exactly one cycle per successful pop, never otherwise.
REQ-026 clr_err=1 SHALL clear ovf/udf next cycle; a new error in the same cycle takes priority (flag set).
REQ-027 tos SHALL never exceed DEPTH nor go below 0; no index wrap-around.
REQ-028 Storage reads SHALL only return previously written entries; stale entries above tos are never output.

Reset
REQ-029 rst=1 at a clock edge SHALL set tos=0, dout=0, dout_valid=0, ovf=0, udf=0; rst overrides push/pop/clr_err in that cycle.
REQ-030 Memory contents need not be cleared on reset; reset mid-operation discards all entries logically (empty=1 next cycle).

Structure
REQ-031 Package pilha_pkg SHALL hold default WIDTH/DEPTH constants and SRC_UC=0 / SRC_ULA=1 select constants.
REQ-032 Storage SHALL be one sub-module pilha_mem: DEPTH x WIDTH register array, synchronous write, combinational read port.
REQ-033 Control (pointer, flags, dout register) SHALL be in pilha_param; no latches; all next-state logic fully assigned.

Verification
REQ-034 Reset then push 0x1111,0x2222 (src_sel=0), pop twice -> dout 0x2222 then 0x1111, each with 1-cycle dout_valid; empty=1 after.
REQ-035 src_sel=1, din_ula=0xDEAD_BEEF push, pop -> dout=0xBEEF.
REQ-036 Push 16 words, 17th push -> full=1, tos=16, ovf=1; pop -> 16th word returned; clr_err -> ovf=0.
REQ-037 Pop when empty -> udf=1, tos=0, dout_valid=0; push+pop when empty -> tos=1, udf=1.
REQ-038 Stack holds 0xA,0xB; push+pop with din_uc=0xC -> dout=0xB, tos=2; pop -> 0xC.
REQ-039 Fill to 5 entries, assert rst one cycle -> tos=0, empty=1, dout=0, flags 0; next pop flags udf.
